selen_wb_master: RTL and testbench
==================================

// Module: selen_wb_master
// PURPOSE
//  Bridges the core/cache memory request channel (valid/ready) to a Wishbone B4 pipelined master port.
//  Its wb_* outputs drive the cluster's wb_* ports directly.
//  Exactly one transaction is outstanding at a time; errors and retries are handled locally.
//  The response is returned on a valid/ready channel.
// PARAMETERS
//  ADDR_W       `CORE_ADDR_WIDTH  address width
//  DATA_W       `CORE_DATA_WIDTH  data width
//  BE_W         `CORE_BE_WIDTH    byte-select width (DATA_W/8)
//  RTY_MAX      3                 wb_rty_i re-issues before reporting error
//  TIMEOUT_CYC  256               watchdog limit in cycles (SELEN_WB_TIMEOUT_EN only)
// PORTS
//  clk        in   1       clock; WB side is synchronous to clk
//  rst_n      in   1       asynchronous active-low reset
//  req_val    in   1       request valid
//  req_rdy    out  1       request ready
//  req_addr   in   ADDR_W  byte address
//  req_wdata  in   DATA_W  write data
//  req_be     in   BE_W    byte enables
//  req_we     in   1       1=write, 0=read
//  req_lock   in   1       locked access -> wb_lock_o
//  req_tga    in   1       address tag (uncached)
//  req_tgc    in   1       cycle tag (1=instruction fetch)
//  rsp_val    out  1       response valid
//  rsp_rdy    in   1       response ready
//  rsp_rdata  out  DATA_W  read data (0 on write or error)
//  rsp_err    out  1       bus error / retry exhausted / timeout
//  wb_dat_i   in   DATA_W  WB read data
//  wb_ack_i   in   1       WB ack
//  wb_err_i   in   1       WB err
//  wb_rty_i   in   1       WB retry
//  wb_stall_i in   1       WB stall
//  wb_dat_o, wb_adr_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_lock_o, wb_tga_o, wb_tgc_o
//             out  DATA_W/ADDR_W/BE_W/1 x6   WB master outputs, all registered
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; every wb_* output, rsp_val, rsp_err, rsp_rdata and rty_cnt = 0.
//   - req_rdy = (state==IDLE), so it reads 1 once state is IDLE.
//  IDLE:
//   - On req_val&&req_rdy, register addr/data/be/we/lock/tga/tgc into wb_*.
//   - Set cyc=stb=1 and go to REQ.
//  REQ:
//   - Hold stb and every wb_* output stable while wb_stall_i=1.
//   - When stall=0, the strobe is accepted: stb<=0 and go to WAIT.
//   - A termination in the same cycle as acceptance is handled as if in WAIT.
//  WAIT (cyc=1, stb=0), termination priority err > rty > ack:
//   - err: rsp_err=1, rsp_rdata=0, cyc<=0, go to RESP.
//   - rty with rty_cnt<RTY_MAX: rty_cnt++, stb<=1 with cyc held, go to REQ.
//   - rty with rty_cnt==RTY_MAX: handled as err.
//   - ack: rsp_rdata = we ? 0 : wb_dat_i, rsp_err=0, cyc<=0, go to RESP.
//  RESP:
//   - rsp_val=1; outputs hold until rsp_rdy.
//   - On rsp_rdy: rsp_val<=0, rty_cnt<=0, go to IDLE (req_rdy high the next cycle).
//  wb_lock_o:
//   - = req_lock, registered with cyc and cleared with cyc.
//   - Also held across retries.
//  Latency (stall=0, ack with accept):
//   - req handshake at cycle 0; cyc/stb at 1; rsp_val at 2.
//   - Back-to-back requests are accepted every 3 cycles minimum.
//  Other rules:
//   - Terminations outside cyc are ignored.
//   - Asserting rst_n low mid-transaction drops cyc/stb immediately, with no response.
// CONFIGURATION
//  SELEN_WB_TIMEOUT_EN defined:
//   - A counter is cleared on entering REQ from IDLE and increments every cycle in REQ/WAIT.
//   - At TIMEOUT_CYC-1 with no termination: cyc<=0, stb<=0, rsp_err=1, go to RESP.
//  SELEN_WB_TIMEOUT_EN undefined:
//   - No counter; the bridge waits for a termination indefinitely.
// STRUCTURE
//  selen_wb_pkg holds:
//   - typedef enum logic[1:0] {IDLE,REQ,WAIT,RESP} wbm_state_t;
//   - struct wbm_req_t (addr, wdata, be, we, lock, tga, tgc);
//   - localparam TIMEOUT_W = $clog2(TIMEOUT_CYC).
//  Single module, no sub-module; the timeout counter is inline under `ifdef.
// TESTING
//  1. Read, stall=0, ack with accept, dat_i=32'hDEADBEEF -> rsp_val at cycle 2, rdata=DEADBEEF, err=0.
//  2. Write addr=32'h100, be=4'b0011, stall 3 cycles -> stb/adr/sel stable 4 cycles; ack -> rsp_err=0.
//  3. rty returned 3 times then ack -> 4 strobes with cyc held high, rsp_err=0.
//  4. rty returned 4 times -> 4 strobes total, rsp_err=1, rdata=0.
//  5. ack and err together -> rsp_err=1; rsp_rdy=0 for 5 cycles -> rsp_val held, req_rdy=0.
//  6. With SELEN_WB_TIMEOUT_EN and no termination -> cyc drops after 256 cycles, rsp_err=1.
//     Reset mid-WAIT -> cyc=0 asynchronously, no rsp_val.

Source files
------------

// File: rtl/selen_wb_pkg.sv
// selen_wb_pkg: shared types and widths for the core-to-Wishbone B4 pipelined master bridge.
// Core widths default to 32/32/4 when the CORE_* macros are not supplied by the build.

`ifndef CORE_ADDR_WIDTH
`define CORE_ADDR_WIDTH 32
`endif
`ifndef CORE_DATA_WIDTH
`define CORE_DATA_WIDTH 32
`endif
`ifndef CORE_BE_WIDTH
`define CORE_BE_WIDTH 4
`endif

package selen_wb_pkg;

    localparam int unsigned CORE_ADDR_W = `CORE_ADDR_WIDTH;
    localparam int unsigned CORE_DATA_W = `CORE_DATA_WIDTH;
    localparam int unsigned CORE_BE_W   = `CORE_BE_WIDTH;
    localparam int unsigned TIMEOUT_CYC = 256;
    localparam int unsigned TIMEOUT_W   = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } wbm_state_t;

    // Captured core request, driven onto the WB outputs for the whole cycle
    typedef struct packed {
        logic [CORE_ADDR_W-1:0] addr;
        logic [CORE_DATA_W-1:0] wdata;
        logic [CORE_BE_W-1:0]   be;
        logic                   we;
        logic                   lock;
        logic                   tga;
        logic                   tgc;
    } wbm_req_t;

endpackage

// File: rtl/selen_wb_master_if.sv
// selen_wb_master_if: Wishbone B4 pipelined master/slave signal bundle.

interface selen_wb_master_if
    import selen_wb_pkg::*;
#(
    parameter int unsigned ADDR_W = CORE_ADDR_W,
    parameter int unsigned DATA_W = CORE_DATA_W,
    parameter int unsigned BE_W   = CORE_BE_W
) ();

    logic [DATA_W-1:0] wb_dat_o;
    logic [ADDR_W-1:0] wb_adr_o;
    logic [BE_W-1:0]   wb_sel_o;
    logic              wb_we_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_lock_o;
    logic              wb_tga_o;
    logic              wb_tgc_o;
    logic [DATA_W-1:0] wb_dat_i;
    logic              wb_ack_i;
    logic              wb_err_i;
    logic              wb_rty_i;
    logic              wb_stall_i;

    modport master (
        output wb_dat_o, wb_adr_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
               wb_lock_o, wb_tga_o, wb_tgc_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
    );

    modport slave (
        input  wb_dat_o, wb_adr_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
               wb_lock_o, wb_tga_o, wb_tgc_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
    );

endinterface

// File: rtl/selen_wb_master.sv
// selen_wb_master: core valid/ready request channel to Wishbone B4 pipelined master,
// one outstanding transaction, local retry/error handling, valid/ready response.
// Optional watchdog enabled by defining SELEN_WB_TIMEOUT_EN.

module selen_wb_master
    import selen_wb_pkg::*;
#(
    parameter int unsigned ADDR_W  = CORE_ADDR_W,
    parameter int unsigned DATA_W  = CORE_DATA_W,
    parameter int unsigned BE_W    = CORE_BE_W,
    parameter int unsigned RTY_MAX = 3
`ifdef SELEN_WB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 256
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_val,
    output logic              req_rdy,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    input  logic              req_we,
    input  logic              req_lock,
    input  logic              req_tga,
    input  logic              req_tgc,
    output logic              rsp_val,
    input  logic              rsp_rdy,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    selen_wb_master_if.master wb
);

    localparam int unsigned RTY_W = (RTY_MAX < 1) ? 1 : $clog2(RTY_MAX + 1);

    wbm_state_t        state_q, state_d;
    wbm_req_t          req_q, req_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              lock_q, lock_d;
    logic              rsp_val_d;
    logic              rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic [RTY_W-1:0]  rty_q, rty_d;
    logic              term_en;
    logic              fin_err;
    logic              fin_ok;

`ifdef SELEN_WB_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    // Next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        lock_d      = lock_q;
        rsp_val_d   = rsp_val;
        rsp_err_d   = rsp_err;
        rsp_rdata_d = rsp_rdata;
        rty_d       = rty_q;
        term_en     = 1'b0;
        fin_err     = 1'b0;
        fin_ok      = 1'b0;
`ifdef SELEN_WB_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_val) begin
                    req_d.addr  = CORE_ADDR_W'(req_addr);
                    req_d.wdata = CORE_DATA_W'(req_wdata);
                    req_d.be    = CORE_BE_W'(req_be);
                    req_d.we    = req_we;
                    req_d.lock  = req_lock;
                    req_d.tga   = req_tga;
                    req_d.tgc   = req_tgc;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    lock_d      = req_lock;
                    state_d     = REQ;
`ifdef SELEN_WB_TIMEOUT_EN
                    tmo_d       = '0;
`endif
                end
            end
            REQ: begin
`ifdef SELEN_WB_TIMEOUT_EN
                tmo_d = TMO_W'(tmo_q + 1'b1);
`endif
                if (!wb.wb_stall_i) begin
                    stb_d   = 1'b0;
                    state_d = WAIT;
                    term_en = 1'b1;
                end
            end
            WAIT: begin
`ifdef SELEN_WB_TIMEOUT_EN
                tmo_d   = TMO_W'(tmo_q + 1'b1);
`endif
                term_en = 1'b1;
            end
            RESP: begin
                if (rsp_rdy) begin
                    rsp_val_d = 1'b0;
                    rty_d     = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Termination priority err > rty > ack; exhausted retries become errors
        if (term_en) begin
            if (wb.wb_err_i || (wb.wb_rty_i && (rty_q == RTY_W'(RTY_MAX)))) begin
                fin_err = 1'b1;
            end else if (wb.wb_rty_i) begin
                rty_d   = RTY_W'(rty_q + 1'b1);
                stb_d   = 1'b1;
                state_d = REQ;
            end else if (wb.wb_ack_i) begin
                fin_ok  = 1'b1;
            end
        end

`ifdef SELEN_WB_TIMEOUT_EN
        if (((state_q == REQ) || (state_q == WAIT)) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1))
            && !(term_en && (wb.wb_err_i || wb.wb_rty_i || wb.wb_ack_i))) begin
            fin_err = 1'b1;
        end
`endif

        if (fin_err || fin_ok) begin
            cyc_d       = 1'b0;
            stb_d       = 1'b0;
            lock_d      = 1'b0;
            rsp_val_d   = 1'b1;
            rsp_err_d   = fin_err;
            rsp_rdata_d = (fin_err || req_q.we) ? '0 : wb.wb_dat_i;
            state_d     = RESP;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            lock_q    <= 1'b0;
            rsp_val   <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            rty_q     <= '0;
            req_rdy   <= 1'b1;
`ifdef SELEN_WB_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            lock_q    <= lock_d;
            rsp_val   <= rsp_val_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            rty_q     <= rty_d;
            req_rdy   <= (state_d == IDLE);
`ifdef SELEN_WB_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    // WB outputs come straight from registers
    assign wb.wb_adr_o  = ADDR_W'(req_q.addr);
    assign wb.wb_dat_o  = DATA_W'(req_q.wdata);
    assign wb.wb_sel_o  = BE_W'(req_q.be);
    assign wb.wb_we_o   = req_q.we;
    assign wb.wb_tga_o  = req_q.tga;
    assign wb.wb_tgc_o  = req_q.tgc;
    assign wb.wb_cyc_o  = cyc_q;
    assign wb.wb_stb_o  = stb_q;
    assign wb.wb_lock_o = lock_q;

endmodule

// File: tb/tb_selen_wb_master.sv
// tb_selen_wb_master: directed and randomized transactions against a transaction-level model.

module tb_selen_wb_master;
    import selen_wb_pkg::*;

    localparam int unsigned AW = CORE_ADDR_W;
    localparam int unsigned DW = CORE_DATA_W;
    localparam int unsigned BW = CORE_BE_W;
    localparam int unsigned RTY_MAX = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_val;
    logic          req_rdy;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          req_we, req_lock, req_tga, req_tgc;
    logic          rsp_val, rsp_rdy, rsp_err;
    logic [DW-1:0] rsp_rdata;

    int n_checks = 0;
    int n_errors = 0;

    selen_wb_master_if wbif ();

    selen_wb_master #(.RTY_MAX(RTY_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_val(req_val), .req_rdy(req_rdy), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_we(req_we),
        .req_lock(req_lock), .req_tga(req_tga), .req_tgc(req_tgc),
        .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .wb(wbif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_terms();
        wbif.wb_ack_i = 1'b0;
        wbif.wb_err_i = 1'b0;
        wbif.wb_rty_i = 1'b0;
        wbif.wb_dat_i = DW'($urandom);
    endtask

    // One full transaction; fin: 0=ack, 1=err, 2=ack+err on the final strobe
    task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [BW-1:0] be, input logic lock, input logic tga, input logic tgc,
                           input int stall_n, input int wait_n, input int rty_n, input int fin,
                           input logic [DW-1:0] rdat, input int hold_n);
        int    exp_strobes;
        logic  exp_err;
        logic [DW-1:0] exp_rdata;
        int    strobes;
        bit    done;
        exp_strobes = (rty_n > int'(RTY_MAX)) ? int'(RTY_MAX) + 1 : rty_n + 1;
        exp_err     = (rty_n > int'(RTY_MAX)) || (fin != 0);
        exp_rdata   = (exp_err || we) ? '0 : rdat;

        check("req_rdy_idle", 64'(req_rdy), 64'd1);
        req_val = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_be = be; req_lock = lock; req_tga = tga; req_tgc = tgc;
        tick();
        req_val = 1'b0; req_addr = AW'($urandom); req_wdata = DW'($urandom);
        req_be = BW'($urandom); req_we = ~we; req_lock = ~lock;

        strobes = 0;
        done = 1'b0;
        for (int k = 0; k < int'(RTY_MAX) + 2 && !done; k++) begin
            check("strobe_cyc_stb", 64'({wbif.wb_cyc_o, wbif.wb_stb_o}), 64'd3);
            check("strobe_adr", 64'(wbif.wb_adr_o), 64'(addr));
            check("strobe_dat", 64'(wbif.wb_dat_o), 64'(wdata));
            check("strobe_sel", 64'(wbif.wb_sel_o), 64'(be));
            check("strobe_attr", 64'({wbif.wb_we_o, wbif.wb_lock_o, wbif.wb_tga_o, wbif.wb_tgc_o}),
                  64'({we, lock, tga, tgc}));
            strobes++;
            for (int s = 0; s < stall_n; s++) begin
                wbif.wb_stall_i = 1'b1;
                tick();
                check("stall_hold", 64'({wbif.wb_cyc_o, wbif.wb_stb_o, wbif.wb_sel_o, wbif.wb_adr_o}),
                      64'({2'b11, be, addr}));
            end
            wbif.wb_stall_i = 1'b0;
            for (int w = 0; w < wait_n; w++) begin
                tick();
                check("wait_cyc_stb", 64'({wbif.wb_cyc_o, wbif.wb_stb_o, wbif.wb_lock_o}),
                      64'({2'b10, lock}));
            end
            if (k < rty_n) wbif.wb_rty_i = 1'b1;
            else begin
                wbif.wb_ack_i = (fin != 1);
                wbif.wb_err_i = (fin != 0);
                wbif.wb_dat_i = rdat;
            end
            tick();
            clear_terms();
            if (!((k < rty_n) && (k < int'(RTY_MAX)))) done = 1'b1;
        end
        check("strobe_count", 64'(strobes), 64'(exp_strobes));
        check("rsp_val", 64'(rsp_val), 64'd1);
        check("rsp_err", 64'(rsp_err), 64'(exp_err));
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
        check("cyc_dropped", 64'({wbif.wb_cyc_o, wbif.wb_stb_o, wbif.wb_lock_o}), 64'd0);
        for (int h = 0; h < hold_n; h++) begin
            rsp_rdy = 1'b0;
            tick();
            check("rsp_hold", 64'({rsp_val, req_rdy, rsp_err}), 64'({2'b10, exp_err}));
            check("rsp_hold_rdata", 64'(rsp_rdata), 64'(exp_rdata));
        end
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        check("rsp_done", 64'({rsp_val, req_rdy}), 64'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; req_val = 1'b0; rsp_rdy = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        req_we = 1'b0; req_lock = 1'b0; req_tga = 1'b0; req_tgc = 1'b0;
        wbif.wb_stall_i = 1'b0;
        clear_terms();
        @(negedge clk);
        check("reset_outputs", 64'({wbif.wb_cyc_o, wbif.wb_stb_o, wbif.wb_lock_o, wbif.wb_we_o,
                                    rsp_val, rsp_err}), 64'd0);
        check("reset_buses", 64'(wbif.wb_adr_o) | 64'(wbif.wb_sel_o) | 64'(rsp_rdata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("reset_req_rdy", 64'(req_rdy), 64'd1);

        // Terminations outside a cycle are ignored
        wbif.wb_ack_i = 1'b1; wbif.wb_err_i = 1'b1; wbif.wb_rty_i = 1'b1;
        tick();
        clear_terms();
        tick();
        check("idle_term_ignored", 64'({rsp_val, wbif.wb_cyc_o, req_rdy}), 64'b001);

        // Directed cases
        run_txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 32'hDEADBEEF, 0);
        run_txn(1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011, 1'b0, 1'b1, 1'b0, 3, 0, 0, 0, 32'hA5A5A5A5, 1);
        run_txn(1'b0, 32'h0000_0200, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1, 1, 3, 0, 32'hCAFEF00D, 0);
        run_txn(1'b0, 32'h0000_0300, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0, 0, 0, 4, 0, 32'h5555AAAA, 0);
        run_txn(1'b0, 32'h0000_0400, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 0, 2, 0, 2, 32'h0BADF00D, 5);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), AW'($urandom), DW'($urandom), BW'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                    DW'($urandom), int'($urandom_range(0, 3)));
        end

`ifdef SELEN_WB_TIMEOUT_EN
        // Watchdog: no termination ever arrives
        req_val = 1'b1; req_we = 1'b0; req_addr = 32'h800;
        tick();
        req_val = 1'b0;
        n = 0;
        while (wbif.wb_cyc_o && n < 400) begin
            tick();
            n++;
        end
        check("timeout_cycles", 64'(n), 64'd256);
        check("timeout_rsp", 64'({rsp_val, rsp_err}), 64'b11);
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
`endif

        // Reset during WAIT drops the cycle at once, no response
        n = 0;
        req_val = 1'b1; req_we = 1'b0; req_addr = 32'h900;
        tick();
        req_val = 1'b0;
        tick();
        check("pre_reset_wait", 64'({wbif.wb_cyc_o, wbif.wb_stb_o}), 64'b10);
        #1 rst_n = 1'b0;
        #1 check("async_reset_cyc", 64'({wbif.wb_cyc_o, wbif.wb_stb_o, rsp_val}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_reset", 64'({rsp_val, req_rdy, wbif.wb_cyc_o}), 64'b010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
